dcache_read_ctrl: RTL and testbench



---
 rtl/dcache_read_ctrl_if.sv | 44 ++++
 rtl/dcache_read_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dcache_read_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_read_ctrl_if.sv
// Bus bundle between the L1 read-path controller and its surroundings:
// core load port, memory word port, and the shared tag/data/valid arrays.
interface dcache_read_ctrl_if;
  logic [31:0]  core_addr;
  logic         core_req;
  logic         core_write;
  logic [2:0]   core_type;
  logic [31:0]  core_out;
  logic         core_wait;
  logic         D_req;
  logic [31:0]  D_addr;
  logic         D_write;
  logic [2:0]   D_type;
  logic [31:0]  D_out;
  logic         D_wait;
  logic [5:0]   index;
  logic         TA_read;
  logic         TA_write;
  logic [21:0]  TA_in;
  logic [21:0]  TA_out;
  logic         DA_read;
  logic [15:0]  DA_write;
  logic [127:0] DA_in;
  logic [127:0] DA_out;
  logic         valid_read;
  logic         valid_write;
  logic         valid_in;

  modport master (
    input  core_addr, core_req, core_write, core_type, D_out, D_wait,
           TA_out, DA_out, valid_in,
    output core_out, core_wait, D_req, D_addr, D_write, D_type, index,
           TA_read, TA_write, TA_in, DA_read, DA_write, DA_in,
           valid_read, valid_write
  );

  modport slave (
    output core_addr, core_req, core_write, core_type, D_out, D_wait,
           TA_out, DA_out, valid_in,
    input  core_out, core_wait, D_req, D_addr, D_write, D_type, index,
           TA_read, TA_write, TA_in, DA_read, DA_write, DA_in,
           valid_read, valid_write
  );
endinterface

// File: rtl/dcache_read_ctrl.sv
// Read-path controller for a direct-mapped write-through L1 data cache
// (64 sets x 16-byte lines, 22-bit tag). Hits return from the arrays in
// two cycles; misses refill the whole line with four in-order word reads.
module dcache_read_ctrl (
  input logic clk,
  input logic rst,
  dcache_read_ctrl_if.master bus
);

  localparam logic [2:0] CACHE_BYTE    = 3'b000;
  localparam logic [2:0] CACHE_HWORD   = 3'b001;
  localparam logic [2:0] CACHE_WORD    = 3'b010;
  localparam logic [2:0] CACHE_BYTE_U  = 3'b100;
  localparam logic [2:0] CACHE_HWORD_U = 3'b101;

  typedef enum logic [2:0] {IDLE, CHECK, REFILL, FILL, DONE} state_t;

  state_t         state;
  logic [31:0]    addr_q;
  logic [2:0]     type_q;
  logic [1:0]     beat;
  logic [127:0]   line_q;
  logic [127:0]   line_nx;
  logic [31:0]    core_out_q;
  logic           wait_q;
  logic           d_req_q;
  logic [31:0]    d_addr_q;
  logic           ta_write_q;
  logic [21:0]    ta_in_q;
  logic           valid_write_q;
  logic [15:0]    da_write_q;
  logic [127:0]   da_in_q;
  logic           accept;
  logic           hit;

  // Pick the addressed word of a line, then size/extend it per load type.
  function automatic logic [31:0] extract(input logic [127:0] line,
                                          input logic [3:0]   off,
                                          input logic [2:0]   typ);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    case (off[3:2])
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      default: w = line[31:0];
    endcase
    case (off[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (typ)
      CACHE_BYTE:    extract = {{24{b[7]}}, b};
      CACHE_BYTE_U:  extract = {24'd0, b};
      CACHE_HWORD:   extract = {{16{h[15]}}, h};
      CACHE_HWORD_U: extract = {16'd0, h};
      CACHE_WORD:    extract = w;
      default:       extract = 32'd0;
    endcase
  endfunction

  // Load accepted this cycle: the array reads must be issued now so their
  // one-cycle synchronous results are ready in CHECK.
  assign accept = (state == IDLE) && bus.core_req && !bus.core_write;
  assign hit    = bus.valid_in && (bus.TA_out == addr_q[31:10]);

  // Line buffer with the current memory beat merged into its word slot.
  always_comb begin
    line_nx = line_q;
    case (beat)
      2'd0:    line_nx[127:96] = bus.D_out;
      2'd1:    line_nx[95:64]  = bus.D_out;
      2'd2:    line_nx[63:32]  = bus.D_out;
      default: line_nx[31:0]   = bus.D_out;
    endcase
  end

  // Read-path FSM; every output except the accept-cycle strobes is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      type_q        <= '0;
      beat          <= '0;
      line_q        <= '0;
      core_out_q    <= '0;
      wait_q        <= 1'b0;
      d_req_q       <= 1'b0;
      d_addr_q      <= '0;
      ta_write_q    <= 1'b0;
      ta_in_q       <= '0;
      valid_write_q <= 1'b0;
      da_write_q    <= 16'hffff;
      da_in_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= bus.core_addr;
            type_q <= bus.core_type;
            wait_q <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            core_out_q <= extract(bus.DA_out, addr_q[3:0], type_q);
            wait_q     <= 1'b0;
            state      <= DONE;
          end else begin
            beat     <= 2'd0;
            line_q   <= '0;
            d_req_q  <= 1'b1;
            d_addr_q <= {addr_q[31:4], 4'b0000};
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (d_req_q && !bus.D_wait) begin
            line_q <= line_nx;
            if (beat == 2'd3) begin
              d_req_q       <= 1'b0;
              d_addr_q      <= '0;
              ta_write_q    <= 1'b1;
              ta_in_q       <= addr_q[31:10];
              valid_write_q <= 1'b1;
              da_write_q    <= 16'h0000;
              da_in_q       <= line_nx;
              state         <= FILL;
            end else begin
              beat     <= beat + 2'd1;
              d_addr_q <= {addr_q[31:4], beat + 2'd1, 2'b00};
            end
          end
        end
        FILL: begin
          core_out_q    <= extract(line_q, addr_q[3:0], type_q);
          wait_q        <= 1'b0;
          ta_write_q    <= 1'b0;
          ta_in_q       <= '0;
          valid_write_q <= 1'b0;
          da_write_q    <= 16'hffff;
          da_in_q       <= '0;
          state         <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.core_out    = core_out_q;
  assign bus.core_wait   = wait_q | accept;
  assign bus.D_req       = d_req_q;
  assign bus.D_addr      = d_addr_q;
  assign bus.D_write     = 1'b0;
  assign bus.D_type      = CACHE_WORD;
  assign bus.index       = (state == IDLE) ? (accept ? bus.core_addr[9:4] : 6'd0)
                                           : addr_q[9:4];
  assign bus.TA_read     = accept;
  assign bus.DA_read     = accept;
  assign bus.valid_read  = accept;
  assign bus.TA_write    = ta_write_q;
  assign bus.TA_in       = ta_in_q;
  assign bus.DA_write    = da_write_q;
  assign bus.DA_in       = da_in_q;
  assign bus.valid_write = valid_write_q;

endmodule

// File: tb/tb_dcache_read_ctrl.sv
// Directed bench for the L1 read-path controller: reset, cold miss, hits of
// every load type, tag mismatch, memory wait states, reset mid-refill, store.
module tb_dcache_read_ctrl;

  localparam logic [2:0] T_BYTE    = 3'b000;
  localparam logic [2:0] T_HWORD   = 3'b001;
  localparam logic [2:0] T_WORD    = 3'b010;
  localparam logic [2:0] T_BYTE_U  = 3'b100;
  localparam logic [2:0] T_HWORD_U = 3'b101;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dcache_read_ctrl_if bus();

  dcache_read_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a load request for one cycle (leaves the FSM in CHECK).
  task automatic issue(input logic [31:0] a, input logic [2:0] t);
    bus.core_addr  = a;
    bus.core_type  = t;
    bus.core_write = 1'b0;
    bus.core_req   = 1'b1;
    #1;
    check("accept_wait", bus.core_wait, 1'b1);
    check("accept_index", bus.index, a[9:4]);
    tick();
    bus.core_req = 1'b0;
    #1;
    check("check_wait", bus.core_wait, 1'b1);
  endtask

  // Full hit: request, CHECK, DONE with the expected data.
  task automatic hit_load(input string tag, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] exp);
    issue(a, t);
    check({tag, "_no_dreq"}, bus.D_req, 1'b0);
    tick();
    #1;
    check({tag, "_wait"}, bus.core_wait, 1'b0);
    check({tag, "_data"}, bus.core_out, exp);
    check({tag, "_no_dreq_done"}, bus.D_req, 1'b0);
    tick();
  endtask

  // Four zero-wait beats; checks D_addr order starting from beat 0.
  task automatic refill(input string tag, input logic [31:0] base, input logic [31:0] d0);
    for (int b = 0; b < 4; b++) begin
      bus.D_out  = d0 + b;
      bus.D_wait = 1'b0;
      #1;
      check({tag, "_dreq"}, bus.D_req, 1'b1);
      check({tag, "_daddr"}, bus.D_addr, base + 32'(4 * b));
      tick();
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b0;
    bus.core_addr  = '0;
    bus.core_req   = 1'b0;
    bus.core_write = 1'b0;
    bus.core_type  = T_WORD;
    bus.D_out      = '0;
    bus.D_wait     = 1'b0;
    bus.TA_out     = '0;
    bus.DA_out     = '0;
    bus.valid_in   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_core_out", bus.core_out, 32'd0);
    check("rst_core_wait", bus.core_wait, 1'b0);
    check("rst_dreq", bus.D_req, 1'b0);
    check("rst_daddr", bus.D_addr, 32'd0);
    check("rst_dwrite", bus.D_write, 1'b0);
    check("rst_dtype", bus.D_type, T_WORD);
    check("rst_index", bus.index, 6'd0);
    check("rst_ta_rd_wr", {bus.TA_read, bus.TA_write, bus.DA_read, bus.valid_read, bus.valid_write}, 5'd0);
    check("rst_da_write", bus.DA_write, 16'hffff);
    check("rst_ta_in", bus.TA_in, 22'd0);
    check("rst_da_in", bus.DA_in, 128'd0);
    #2 rst = 1'b1;
    tick();
    tick();
    check("idle_da_write", bus.DA_write, 16'hffff);
    check("idle_wait", bus.core_wait, 1'b0);
    check("idle_dreq", bus.D_req, 1'b0);

    // Cold miss: WORD load of 0x1234
    bus.valid_in = 1'b0;
    issue(32'h0000_1234, T_WORD);
    check("cold_check_reads", {bus.TA_read, bus.DA_read, bus.valid_read}, 3'b000);
    tick();
    refill("cold", 32'h0000_1230, 32'h0000_00A0);
    check("cold_fill_ta_write", bus.TA_write, 1'b1);
    check("cold_fill_ta_in", bus.TA_in, 22'h4);
    check("cold_fill_index", bus.index, 6'h23);
    check("cold_fill_da_in", bus.DA_in, {32'hA0, 32'hA1, 32'hA2, 32'hA3});
    check("cold_fill_da_write", bus.DA_write, 16'h0000);
    check("cold_fill_valid_write", bus.valid_write, 1'b1);
    check("cold_fill_wait", bus.core_wait, 1'b1);
    check("cold_fill_dreq", bus.D_req, 1'b0);
    tick();
    check("cold_done_wait", bus.core_wait, 1'b0);
    check("cold_done_data", bus.core_out, 32'h0000_00A1);
    check("cold_done_da_write", bus.DA_write, 16'hffff);
    check("cold_done_ta_write", bus.TA_write, 1'b0);
    tick();
    check("cold_idle_wait", bus.core_wait, 1'b0);

    // Hits on the filled line
    bus.TA_out   = 22'h4;
    bus.valid_in = 1'b1;
    bus.DA_out   = {32'h0, 32'h0000_80FF, 32'h0, 32'h0};
    hit_load("hit_byte", 32'h0000_1235, T_BYTE, 32'hFFFF_FF80);
    hit_load("hit_byte_u", 32'h0000_1235, T_BYTE_U, 32'h0000_0080);
    bus.DA_out   = {32'h1111_2222, 32'h8001_1234, 32'h3333_4444, 32'h5555_6666};
    hit_load("hit_hword", 32'h0000_1236, T_HWORD, 32'hFFFF_8001);
    hit_load("hit_hword_u", 32'h0000_1234, T_HWORD_U, 32'h0000_1234);
    hit_load("hit_word3", 32'h0000_123C, T_WORD, 32'h5555_6666);
    hit_load("hit_unknown", 32'h0000_1234, 3'b111, 32'h0000_0000);

    // Tag mismatch with valid set is a miss
    bus.TA_out   = 22'h5;
    bus.valid_in = 1'b1;
    issue(32'h0000_1234, T_WORD);
    tick();
    refill("mism", 32'h0000_1230, 32'h0000_00C0);
    check("mism_fill_da_write", bus.DA_write, 16'h0000);
    check("mism_fill_ta_in", bus.TA_in, 22'h4);
    tick();
    check("mism_done_wait", bus.core_wait, 1'b0);
    check("mism_done_data", bus.core_out, 32'h0000_00C1);
    tick();

    // D_wait held three cycles on beat 1
    bus.valid_in = 1'b0;
    issue(32'h0000_1234, T_WORD);
    tick();
    bus.D_out  = 32'h0000_00D0;
    bus.D_wait = 1'b0;
    #1;
    check("wait_b0_daddr", bus.D_addr, 32'h0000_1230);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.D_out  = 32'hDEAD_BEEF;
      bus.D_wait = 1'b1;
      #1;
      check("wait_hold_daddr", bus.D_addr, 32'h0000_1234);
      check("wait_hold_dreq", bus.D_req, 1'b1);
      tick();
    end
    bus.D_out  = 32'h0000_00D1;
    bus.D_wait = 1'b0;
    #1;
    check("wait_b1_daddr", bus.D_addr, 32'h0000_1234);
    tick();
    bus.D_out = 32'h0000_00D2;
    tick();
    bus.D_out = 32'h0000_00D3;
    #1;
    check("wait_b3_daddr", bus.D_addr, 32'h0000_123C);
    tick();
    check("wait_fill_wait", bus.core_wait, 1'b1);
    check("wait_fill_da_in", bus.DA_in, {32'hD0, 32'hD1, 32'hD2, 32'hD3});
    tick();
    check("wait_done_t10", bus.core_wait, 1'b0);
    check("wait_done_data", bus.core_out, 32'h0000_00D1);
    tick();

    // Reset pulse during beat 2
    issue(32'h0000_1234, T_WORD);
    tick();
    bus.D_out = 32'h0000_00E0;
    tick();
    bus.D_out = 32'h0000_00E1;
    tick();
    bus.D_out = 32'h0000_00E2;
    #1;
    check("rstmid_b2_daddr", bus.D_addr, 32'h0000_1238);
    rst = 1'b0;
    #1;
    check("rstmid_wait", bus.core_wait, 1'b0);
    check("rstmid_dreq", bus.D_req, 1'b0);
    check("rstmid_da_write", bus.DA_write, 16'hffff);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_no_writes", {bus.TA_write, bus.valid_write, bus.D_req}, 3'b000);
      check("rstmid_no_da_write", bus.DA_write, 16'hffff);
    end
    issue(32'h0000_1238, T_WORD);
    tick();
    refill("rerefill", 32'h0000_1230, 32'h0000_00F0);
    check("rerefill_da_in", bus.DA_in, {32'hF0, 32'hF1, 32'hF2, 32'hF3});
    tick();
    check("rerefill_data", bus.core_out, 32'h0000_00F2);
    tick();

    // Store request is ignored
    bus.core_addr  = 32'h0000_1234;
    bus.core_write = 1'b1;
    bus.core_req   = 1'b1;
    #1;
    check("store_wait", bus.core_wait, 1'b0);
    check("store_reads", {bus.TA_read, bus.DA_read, bus.valid_read}, 3'b000);
    tick();
    bus.core_req   = 1'b0;
    bus.core_write = 1'b0;
    #1;
    check("store_after_wait", bus.core_wait, 1'b0);
    check("store_after_dreq", bus.D_req, 1'b0);
    check("store_after_index", bus.index, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
